rx: RTL
=======

// Module: rx
// PURPOSE
//  UART serial receiver; pairs with the tx block across the serial line. Oversamples in_bit on rx_Clk,
//  detects the start bit, samples each bit at mid-period and assembles a 10-bit frame (start, 8 data, stop).
//  The frame is presented MSB-first: the first bit received lands in o_rx_byte[9], matching tx shift order.
//  Flags stop-bit violations and rejects glitch starts.
// PARAMETERS
//  CLKS_PER_BIT  16  rx_Clk cycles per serial bit; legal range >= 4; counter width = $clog2(CLKS_PER_BIT)
// PORTS
//  rx_Clk      in   1   receive clock, all logic on posedge
//  rx_Rst_n    in   1   asynchronous, active-low reset
//  in_bit      in   1   serial line, idle high, asynchronous to rx_Clk
//  rx_enable   in   1   1 = start detection allowed; 0 = stay in IDLE (frame in progress still completes)
//  o_rx_byte   out  10  last received frame; [9]=start, [8:1]=data (first data bit in [8]), [0]=stop
//  rx_done     out  1   1-cycle pulse: o_rx_byte updated this cycle
//  frame_err   out  1   1-cycle pulse coincident with rx_done when sampled stop bit was 0
//  rx_busy     out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Reset (async, rx_Rst_n=0): state=IDLE, o_rx_byte=10'h3FF, rx_done=0, frame_err=0, rx_busy=0,
//   synchronizer flops=1, counters=0. Reset mid-frame aborts; no rx_done is issued for the aborted frame.
//  Input sync: 2-flop synchronizer (s1 -> s2) plus s2_d history flop; all decisions use s2. Latency 2 cycles.
//  Falling edge = s2_d==1 && s2==0.
//  Counters: clk_cnt counts rx_Clk within a bit; bit_cnt counts data bits 0..7. Both reset to 0 on each state entry.
//  FSM:
//   IDLE : rx_busy=0. If rx_enable && falling edge -> START.
//          A line held low (break, or after frame_err) never re-triggers; a new high->low edge is required.
//   START: When clk_cnt == CLKS_PER_BIT/2-1 (integer div), sample s2.
//          s2==0 -> shift 0 into frame, go to DATA.
//          s2==1 -> glitch; go to IDLE with no pulse.
//   DATA : When clk_cnt == CLKS_PER_BIT-1, sample s2 into the shift register (shift toward MSB), bit_cnt+1.
//          Go to STOP after the 8th sample.
//   STOP : When clk_cnt == CLKS_PER_BIT-1, sample s2 as stop bit.
//          o_rx_byte <= {start, data[7:0], stop}; rx_done=1 for 1 cycle.
//          frame_err=1 that cycle if stop==0. Go to IDLE next cycle.
//  The frame is only written to o_rx_byte in STOP. o_rx_byte holds its value otherwise.
//  Timing: from the first rx_Clk edge where s2 goes low, rx_done asserts after
//   CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles. The next start can be detected from the cycle after rx_done
//   (before the stop bit ends), so back-to-back frames with no idle gap are received.
//  rx_enable deasserting while rx_busy=1 has no effect on the current frame.
//  rx_done and frame_err are registered outputs, never asserted together outside STOP completion.
// TESTING (CLKS_PER_BIT=16)
//  1. Reset: hold rx_Rst_n=0 mid-frame -> o_rx_byte=3FF, rx_done=0, rx_busy=0 immediately (async).
//  2. Send frame 0,10100101,1 (16 clks/bit) -> rx_done pulse once, o_rx_byte=10'b0101001011, frame_err=0.
//     Pulse occurs 152 clks after s2 falls.
//  3. Glitch: in_bit low for 5 clks then high -> rx_busy returns 0 with no rx_done; the next valid frame
//     0x3C is received correctly.
//  4. Stop bit driven 0 with data 0xFF -> rx_done=1 and frame_err=1 in the same cycle,
//     o_rx_byte=10'b0111111110. Line held low 40 more clks -> no new frame.
//  5. Back-to-back frames 0x00 then 0xFF with zero idle -> two rx_done pulses 160 clks apart,
//     both with frame_err=0.
//  6. rx_enable=0 during a start edge -> ignored. rx_enable dropped mid-frame -> that frame still completes.

Source files
------------

// File: rtl/rx.sv
// UART receiver: 2-flop synchronised serial input, mid-bit sampling, and a 10-bit frame
// presented MSB-first ({start, data in arrival order, stop}), with frame-error and busy flags.
module rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       rx_Clk,
  input  logic       rx_Rst_n,
  input  logic       in_bit,
  input  logic       rx_enable,
  output logic [9:0] o_rx_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LP_CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LP_CNT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_CNT_ONE = CW'(1);
  localparam logic [2:0]    LP_BIT_LAST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_s1;
  logic            r_s2;
  logic            r_s2_d;
  logic [CW-1:0]   r_clk_cnt;
  logic [CW-1:0]   w_clk_cnt_nxt;
  logic [2:0]      r_bit_cnt;
  logic [2:0]      w_bit_cnt_nxt;
  logic [8:0]      r_shift;
  logic [8:0]      w_shift_nxt;
  logic [9:0]      r_rx_byte;
  logic [9:0]      w_rx_byte_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            r_ferr;
  logic            w_ferr_nxt;
  logic            r_busy;
  logic            w_fall;
  logic            w_cnt_mid;
  logic            w_cnt_end;
  logic            w_last_bit;
  logic            w_state_chg;

  // Line synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge rx_Clk or negedge rx_Rst_n) begin
    if (!rx_Rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_s2_d <= 1'b1;
    end else begin
      r_s1   <= in_bit;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  assign w_fall      = r_s2_d & ~r_s2;
  assign w_cnt_mid   = (r_clk_cnt == LP_CNT_MID);
  assign w_cnt_end   = (r_clk_cnt == LP_CNT_END);
  assign w_last_bit  = (r_bit_cnt == LP_BIT_LAST);
  assign w_state_chg = (w_state_nxt != r_state);

  // FSM state register.
  always_ff @(posedge rx_Clk or negedge rx_Rst_n) begin
    if (!rx_Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; only IDLE looks at rx_enable, so a frame in flight always completes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rx_enable && w_fall) begin
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_cnt_mid) begin
          w_state_nxt = r_s2 ? ST_IDLE : ST_DATA;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_cnt_end && w_last_bit) begin
          w_state_nxt = ST_STOP;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_STOP: begin
        if (w_cnt_end) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM output/datapath logic: counters, shift register and the completed-frame outputs.
  always_comb begin
    w_shift_nxt   = r_shift;
    w_rx_byte_nxt = r_rx_byte;
    w_done_nxt    = 1'b0;
    w_ferr_nxt    = 1'b0;

    if (w_state_chg || (r_state == ST_IDLE) || w_cnt_end) begin
      w_clk_cnt_nxt = '0;
    end else begin
      w_clk_cnt_nxt = r_clk_cnt + LP_CNT_ONE;
    end

    if (w_state_chg) begin
      w_bit_cnt_nxt = 3'd0;
    end else if ((r_state == ST_DATA) && w_cnt_end) begin
      w_bit_cnt_nxt = r_bit_cnt + 3'd1;
    end else begin
      w_bit_cnt_nxt = r_bit_cnt;
    end

    case (r_state)
      ST_START: begin
        if (w_cnt_mid && !r_s2) begin
          w_shift_nxt = {r_shift[7:0], 1'b0};
        end else begin
          w_shift_nxt = r_shift;
        end
      end
      ST_DATA: begin
        if (w_cnt_end) begin
          w_shift_nxt = {r_shift[7:0], r_s2};
        end else begin
          w_shift_nxt = r_shift;
        end
      end
      ST_STOP: begin
        if (w_cnt_end) begin
          w_rx_byte_nxt = {r_shift, r_s2};
          w_done_nxt    = 1'b1;
          w_ferr_nxt    = ~r_s2;
        end else begin
          w_rx_byte_nxt = r_rx_byte;
          w_done_nxt    = 1'b0;
          w_ferr_nxt    = 1'b0;
        end
      end
      ST_IDLE: begin
        w_shift_nxt = r_shift;
      end
      default: begin
        w_shift_nxt = r_shift;
      end
    endcase
  end

  // Datapath and output registers; busy is registered from the next state so it tracks the FSM exactly.
  always_ff @(posedge rx_Clk or negedge rx_Rst_n) begin
    if (!rx_Rst_n) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 9'd0;
      r_rx_byte <= 10'h3FF;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_rx_byte <= w_rx_byte_nxt;
      r_done    <= w_done_nxt;
      r_ferr    <= w_ferr_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_rx_byte = r_rx_byte;
  assign rx_done   = r_done;
  assign frame_err = r_ferr;
  assign rx_busy   = r_busy;

endmodule
